// File: rtl/clock_ctrl.sv
// 24-hour clock controller: debounced-by-sync push-button decoding, RUN/STOPPED/SET FSM
// and HH:MM:SS counters advanced by an external 1 Hz tick.
module clock_ctrl #(
    parameter int START_RUNNING = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       key_startstop_n,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    output logic       timer_enable,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       day_wrap
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STOPPED = 2'd1,
        ST_SET_HH  = 2'd2,
        ST_SET_MM  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = (START_RUNNING != 0) ? ST_RUN : ST_STOPPED;
    localparam logic   RESET_TE    = (START_RUNNING != 0);

    // Key bit order everywhere below: [0] startstop, [1] mode, [2] inc.
    logic [2:0] r_sync [SYNC_STAGES];
    logic [2:0] r_hist;
    logic [2:0] r_ev;
    logic [2:0] w_sync_out;

    state_t     r_state;
    state_t     w_state_n;
    logic       r_timer_en;
    logic [4:0] r_hours;
    logic [5:0] r_minutes;
    logic [5:0] r_seconds;
    logic       r_day_wrap;

    logic       w_do_mode;
    logic       w_do_ss;
    logic       w_do_inc;
    logic       w_tick_run;
    logic [4:0] w_hours_n;
    logic [5:0] w_minutes_n;
    logic [5:0] w_seconds_n;
    logic       w_day_wrap_n;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // History resets high so a key held through reset still yields one press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '1;
            end
            r_hist <= '1;
            r_ev   <= '0;
        end else begin
            r_sync[0] <= {key_inc_n, key_mode_n, key_startstop_n};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= w_sync_out;
            r_ev   <= r_hist & ~w_sync_out;
        end
    end

    assign w_do_mode  = r_ev[1];
    assign w_do_ss    = r_ev[0] & ~r_ev[1];
    assign w_do_inc   = r_ev[2] & ~r_ev[1] & ~r_ev[0];
    assign w_tick_run = tick_1hz && (r_state == ST_RUN);

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_do_mode) begin
                    w_state_n = ST_SET_HH;
                end else if (w_do_ss) begin
                    w_state_n = ST_STOPPED;
                end
            end
            ST_STOPPED: begin
                if (w_do_mode) begin
                    w_state_n = ST_SET_HH;
                end else if (w_do_ss) begin
                    w_state_n = ST_RUN;
                end
            end
            ST_SET_HH: begin
                if (w_do_mode) begin
                    w_state_n = ST_SET_MM;
                end
            end
            ST_SET_MM: begin
                if (w_do_mode) begin
                    w_state_n = ST_RUN;
                end
            end
            default: w_state_n = RESET_STATE;
        endcase
    end

    // Tick carry is computed first; a same-cycle mode press then overrides seconds only.
    always_comb begin
        w_hours_n    = r_hours;
        w_minutes_n  = r_minutes;
        w_seconds_n  = r_seconds;
        w_day_wrap_n = 1'b0;
        if (w_tick_run) begin
            if (r_seconds == 6'd59) begin
                w_seconds_n = 6'd0;
                if (r_minutes == 6'd59) begin
                    w_minutes_n = 6'd0;
                    if (r_hours == 5'd23) begin
                        w_hours_n    = 5'd0;
                        w_day_wrap_n = 1'b1;
                    end else begin
                        w_hours_n = r_hours + 5'd1;
                    end
                end else begin
                    w_minutes_n = r_minutes + 6'd1;
                end
            end else begin
                w_seconds_n = r_seconds + 6'd1;
            end
        end
        if (w_do_mode && (r_state == ST_RUN || r_state == ST_STOPPED)) begin
            w_seconds_n = 6'd0;
        end
        if (w_do_inc && r_state == ST_SET_HH) begin
            w_hours_n = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
        end
        if (w_do_inc && r_state == ST_SET_MM) begin
            w_minutes_n = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RESET_STATE;
            r_timer_en <= RESET_TE;
            r_hours    <= 5'd0;
            r_minutes  <= 6'd0;
            r_seconds  <= 6'd0;
            r_day_wrap <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_timer_en <= (w_state_n == ST_RUN);
            r_hours    <= w_hours_n;
            r_minutes  <= w_minutes_n;
            r_seconds  <= w_seconds_n;
            r_day_wrap <= w_day_wrap_n;
        end
    end

    assign mode         = r_state;
    assign timer_enable = r_timer_en;
    assign hours        = r_hours;
    assign minutes      = r_minutes;
    assign seconds      = r_seconds;
    assign day_wrap     = r_day_wrap;

endmodule
